// File: rtl/add_sub_ctrl_if.sv
// add_sub_ctrl_if: request, add_sub datapath and result signals of add_sub_ctrl
// slave modport is the sequencer; master modport is its environment
// (upstream requester, add_sub datapath and downstream consumer).
interface add_sub_ctrl_if #(parameter int WIDTH = 4, parameter int CNT_W = 8);
  logic in_valid, in_ready, in_mode, in_acc;
  logic [WIDTH-1:0] in_a, in_b;
  logic [WIDTH-1:0] as_a, as_b, as_sdout;
  logic as_en, as_cbout;
  logic out_valid, out_ready, out_cb, out_zero, out_ovf;
  logic [WIDTH-1:0] out_result;
  logic [CNT_W-1:0] op_count;
  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_acc, as_sdout, as_cbout, out_ready,
    output in_ready, as_a, as_b, as_en, out_valid, out_result, out_cb, out_zero, out_ovf, op_count
  );
  modport master (
    output in_valid, in_a, in_b, in_mode, in_acc, as_sdout, as_cbout, out_ready,
    input  in_ready, as_a, as_b, as_en, out_valid, out_result, out_cb, out_zero, out_ovf, op_count
  );
endinterface

// File: rtl/add_sub_ctrl.sv
// add_sub_ctrl: valid/ready sequencer driving a combinational add_sub datapath
// clk, rst_n (async active-low); bus.slave carries the request handshake
// (in_*), registered add_sub operands (as_a/as_b/as_en) and its results
// (as_sdout/as_cbout), and the result handshake with flags and op_count.
module add_sub_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  add_sub_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam int MSB = WIDTH - 1;
  state_t state, nxt;
  logic [WIDTH-1:0] acc;
  logic ovf;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = bus.in_valid ? EXEC : IDLE;
      EXEC: nxt = DONE;
      DONE: nxt = bus.out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // Subtract overflows when signs differ, add when they match: compare A with B^mode.
  assign ovf = (bus.as_a[MSB] == (bus.as_b[MSB] ^ bus.as_en)) && (bus.as_sdout[MSB] != bus.as_a[MSB]);
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      bus.as_a <= '0;
      bus.as_b <= '0;
      bus.as_en <= 1'b0;
      bus.out_result <= '0;
      bus.out_cb <= 1'b0;
      bus.out_zero <= 1'b0;
      bus.out_ovf <= 1'b0;
      bus.op_count <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.in_valid) begin
        bus.as_a <= bus.in_acc ? acc : bus.in_a;
        bus.as_b <= bus.in_b;
        bus.as_en <= bus.in_mode;
      end
      if (state == EXEC) begin
        bus.out_result <= bus.as_sdout;
        bus.out_cb <= bus.as_cbout;
        bus.out_zero <= bus.as_sdout == '0;
        bus.out_ovf <= ovf;
        acc <= bus.as_sdout;
      end
      if (state == DONE && bus.out_ready) bus.op_count <= bus.op_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_add_sub_ctrl.sv
// tb_add_sub_ctrl: table-driven check of add_sub_ctrl against a behavioural add_sub
module tb_add_sub_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass_cnt = 0;
  int total = 0;
  int ops = 0;
  always #5 clk = ~clk;
  add_sub_ctrl_if #(.WIDTH(4), .CNT_W(8)) bus ();
  add_sub_ctrl #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  logic [4:0] sum5;
  always_comb begin
    sum5 = {1'b0, bus.as_a} + {1'b0, bus.as_b};
    bus.as_sdout = bus.as_en ? bus.as_a - bus.as_b : sum5[3:0];
    bus.as_cbout = bus.as_en ? bus.as_a < bus.as_b : sum5[4];
  end
  typedef struct {
    logic [3:0] a, b;
    logic mode, acc;
    logic [3:0] exp_a, exp_r;
    logic exp_cb, exp_z, exp_ovf;
  } vec_t;
  vec_t v[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic op(input vec_t t, input bit full);
    @(negedge clk);
    if (full) chk("in_ready_idle", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_a = t.a;
    bus.in_b = t.b;
    bus.in_mode = t.mode;
    bus.in_acc = t.acc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (full) begin
      chk("exec_out_valid", 32'(bus.out_valid), 0);
      chk("exec_in_ready", 32'(bus.in_ready), 0);
      chk("as_a", 32'(bus.as_a), 32'(t.exp_a));
      chk("as_b", 32'(bus.as_b), 32'(t.b));
      chk("as_en", 32'(bus.as_en), 32'(t.mode));
    end
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 1);
    if (full) begin
      chk("out_result", 32'(bus.out_result), 32'(t.exp_r));
      chk("out_cb", 32'(bus.out_cb), 32'(t.exp_cb));
      chk("out_zero", 32'(bus.out_zero), 32'(t.exp_z));
      chk("out_ovf", 32'(bus.out_ovf), 32'(t.exp_ovf));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    ops++;
    if (full) begin
      chk("done_out_valid", 32'(bus.out_valid), 0);
      chk("done_in_ready", 32'(bus.in_ready), 1);
      chk("op_count", 32'(bus.op_count), 32'(ops % 256));
    end
  endtask
  initial begin
    //          a      b      m     acc   exp_a  exp_r  cb    z     ovf
    v[0] = '{4'hF, 4'h3, 1'b0, 1'b1, 4'h0, 4'h3, 1'b0, 1'b0, 1'b0};
    v[1] = '{4'hA, 4'h5, 1'b0, 1'b0, 4'hA, 4'hF, 1'b0, 1'b0, 1'b0};
    v[2] = '{4'h4, 4'h7, 1'b1, 1'b0, 4'h4, 4'hD, 1'b1, 1'b0, 1'b0};
    v[3] = '{4'hA, 4'h5, 1'b1, 1'b0, 4'hA, 4'h5, 1'b0, 1'b0, 1'b1};
    v[4] = '{4'h9, 4'hF, 1'b0, 1'b0, 4'h9, 4'h8, 1'b1, 1'b0, 1'b0};
    v[5] = '{4'h7, 4'h1, 1'b0, 1'b0, 4'h7, 4'h8, 1'b0, 1'b0, 1'b1};
    v[6] = '{4'h5, 4'hB, 1'b0, 1'b0, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0};
    v[7] = '{4'h3, 4'h4, 1'b0, 1'b0, 4'h3, 4'h7, 1'b0, 1'b0, 1'b0};
    v[8] = '{4'hF, 4'h2, 1'b1, 1'b1, 4'h7, 4'h5, 1'b0, 1'b0, 1'b0};
    v[9] = '{4'hE, 4'h5, 1'b1, 1'b1, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0};
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_mode = 1'b0;
    bus.in_acc = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_result", 32'(bus.out_result), 0);
    chk("rst_flags", 32'({bus.out_cb, bus.out_zero, bus.out_ovf}), 0);
    chk("rst_as", 32'({bus.as_a, bus.as_b, bus.as_en}), 0);
    chk("rst_op_count", 32'(bus.op_count), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) op(v[i], 1'b1);
    // backpressure: DONE must hold with out_ready low and new requests pending
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a = 4'h6;
    bus.in_b = 4'h1;
    bus.in_mode = 1'b0;
    bus.in_acc = 1'b0;
    @(negedge clk);
    bus.in_a = 4'h0;
    bus.in_b = 4'h9;
    bus.in_mode = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_result", 32'({bus.out_result, bus.out_cb, bus.out_zero, bus.out_ovf}), 32'({4'h7, 3'b000}));
      chk("bp_as", 32'({bus.as_a, bus.as_b, bus.as_en}), 32'({4'h6, 4'h1, 1'b0}));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    ops++;
    chk("bp_op_count", 32'(bus.op_count), 32'(ops));
    chk("bp_idle", 32'(bus.in_ready), 1);
    // reset during EXEC drops the operation asynchronously
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a = 4'h2;
    bus.in_b = 4'h2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre_rst_exec", 32'(bus.in_ready), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_as", 32'({bus.as_a, bus.as_b, bus.as_en}), 0);
    chk("mid_rst_result", 32'({bus.out_result, bus.out_cb, bus.out_zero, bus.out_ovf}), 0);
    chk("mid_rst_op_count", 32'(bus.op_count), 0);
    @(negedge clk);
    chk("rst_held_out_valid", 32'(bus.out_valid), 0);
    rst_n = 1'b1;
    ops = 0;
    // accumulator was cleared by reset: acc op starts from A=0
    op('{4'hC, 4'h1, 1'b0, 1'b1, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0}, 1'b1);
    for (int i = 0; i < 254; i++) op(v[1], 1'b0);
    chk("op_count_255", 32'(bus.op_count), 255);
    op(v[1], 1'b0);
    chk("op_count_wrap", 32'(bus.op_count), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/add_sub_ctrl.md
# add_sub_ctrl

Operation sequencer that sits directly upstream of the 4-bit `add_sub` datapath. It accepts add/subtract requests over a valid/ready handshake and registers the operands and mode onto the `add_sub` inputs. One cycle later it captures `sdout`/`cbout`, then presents the result with derived status flags over a second valid/ready handshake. An accumulate option chains the previous result in as operand A, so multi-step arithmetic runs without the upstream master holding state.

## Interface
- `WIDTH`, 4, operand/result width; must match `add_sub`.
- `CNT_W`, 8, width of the completed-operation counter.

- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  request valid.
- `in_ready`  output  1  block can accept a request.
- `in_a`  input  WIDTH  operand A; ignored when `in_acc`=1.
- `in_b`  input  WIDTH  operand B.
- `in_mode`  input  1  0 = add, 1 = subtract (A−B).
- `in_acc`  input  1  1 = use last captured result as A.
- `as_a`  output  WIDTH  registered operand A to `add_sub`.
- `as_b`  output  WIDTH  registered operand B to `add_sub`.
- `as_en`  output  1  registered mode to `add_sub` `en`.
- `as_sdout`  input  WIDTH  sum/difference from `add_sub`.
- `as_cbout`  input  1  carry (add) / borrow (sub) from `add_sub`.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  downstream accepts result.
- `out_result`  output  WIDTH  captured `as_sdout`.
- `out_cb`  output  1  captured `as_cbout`.
- `out_zero`  output  1  `out_result` == 0.
- `out_ovf`  output  1  two's-complement signed overflow.
- `op_count`  output  CNT_W  completed output handshakes, wraps.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`:
  - load `as_a` ← (`in_acc` ? `acc_reg` : `in_a`), `as_b` ← `in_b`, `as_en` ← `in_mode`;
  - go to EXEC.
- EXEC: `in_ready`=0. `add_sub` settles combinationally. At the next edge:
  - capture `out_result` ← `as_sdout`, `out_cb` ← `as_cbout`, `acc_reg` ← `as_sdout`;
  - register `out_zero` and `out_ovf`;
  - set `out_valid`=1 and go to DONE.
- DONE: `in_ready`=0; all `out_*` held stable. On `out_valid`&&`out_ready`:
  - clear `out_valid`, increment `op_count`, return to IDLE.
- `as_a`/`as_b`/`as_en` hold their values outside the load edge.
- Overflow, with A=`as_a`, B=`as_b`, R=`as_sdout` and MSB index WIDTH−1:
  - add: A[MSB]==B[MSB] && R[MSB]!=A[MSB];
  - sub: A[MSB]!=B[MSB] && R[MSB]!=A[MSB].
- `cbout` semantics are owned by `add_sub`: carry-out of A+B on add; borrow (1 iff A<B, unsigned) on subtract. The block passes the value through unmodified.
- `op_count` wraps from 2^CNT_W−1 to 0 with no flag.
- `acc_reg` updates only in EXEC and is not cleared by output handshakes.

## Timing
- Reset values: `in_ready`=1 (state IDLE), `out_valid`=0, `out_result`=0, `out_cb`=0, `out_zero`=0, `out_ovf`=0, `as_a`=0, `as_b`=0, `as_en`=0, `acc_reg`=0, `op_count`=0.
- Latency: input handshake at edge k → `out_valid`=1 after edge k+1.
- Throughput: one operation per 3 cycles with `out_ready` held high.
- Backpressure: DONE persists indefinitely while `out_ready`=0, with outputs stable.
- `in_valid` during EXEC/DONE is not accepted; upstream must hold its request.
- `in_acc`=1 on the first operation after reset uses A=0.
- Reset asserted in any state clears everything immediately (asynchronously); an in-flight operation is dropped and `op_count` is not incremented.

## Test plan
- Add: A=1010, B=0101, mode 0 → `out_result`=1111, `cb`=0, `zero`=0, `ovf`=0, `out_valid` two edges after accept.
- Sub with borrow: A=0100, B=0111, mode 1 → 1101, `cb`=1, `ovf`=0. Then A=1010, B=0101, mode 1 → 0101, `cb`=0, `ovf`=1.
- Carry and overflow: A=1001, B=1111 add → 1000, `cb`=1, `ovf`=0. A=0111, B=0001 add → 1000, `cb`=0, `ovf`=1. A=0101, B=1011 add → 0000, `zero`=1, `cb`=1.
- Accumulate chain: 0011+0100 (`acc`=0) → 0111; then `acc`=1, B=0010, sub → 0101; then `acc`=1, B=0101, sub → 0000, `zero`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0, `in_valid` ignored. Raise `out_ready` → `op_count`+1, IDLE next cycle.
- Reset mid-op: assert `rst_n`=0 during EXEC → all outputs at reset values immediately, `op_count` unchanged from 0. Also: 256 operations → `op_count` wraps to 0.
